// File: rtl/systolic_array_tile_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_tile_sequencer_if
// Description : AXIS handshake bundle observed and gated by the tile sequencer
// Revision    : 1.0
// ============================================================================
interface systolic_array_tile_sequencer_if;
    logic s_tvalid;
    logic s_tlast;
    logic s_tready;
    logic m_tvalid;
    logic m_tready;
    logic out_last;

    modport slave (
        input  s_tvalid,
        input  s_tlast,
        input  m_tvalid,
        input  m_tready,
        output s_tready,
        output out_last
    );

    modport master (
        output s_tvalid,
        output s_tlast,
        output m_tvalid,
        output m_tready,
        input  s_tready,
        input  out_last
    );
endinterface
`default_nettype wire

// File: rtl/systolic_array_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_tile_sequencer
// Description : Control-only weight-load / activation-stream / drain sequencer
//               for one systolic-array tile pass, with result beat counting.
// Revision    : 1.0
// ============================================================================
module systolic_array_tile_sequencer #(
    parameter int DATA_WIDTH   = 9,
    parameter int ARRAY_DIM    = 16,
    parameter int CNT_WIDTH    = 16,
    parameter int DRAIN_CYCLES = 31
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         start,
    input  wire logic                         abort,
    input  wire logic [CNT_WIDTH-1:0]         act_beats,
    input  wire logic                         out_afull,
    output logic                              wgt_we,
    output logic [$clog2(ARRAY_DIM)-1:0]      wgt_row,
    output logic                              act_en,
    output logic                              act_bubble,
    output logic                              busy,
    output logic                              done,
    output logic                              proto_err,
    systolic_array_tile_sequencer_if.slave    axis
);

    localparam int                     c_ROW_W    = $clog2(ARRAY_DIM);
    localparam logic [c_ROW_W-1:0]     c_LAST_ROW = c_ROW_W'(ARRAY_DIM - 1);
    localparam logic [CNT_WIDTH-1:0]   c_LAST_DRN = CNT_WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   c_ONE      = CNT_WIDTH'(1);

    generate
        if (ARRAY_DIM < 2 || DRAIN_CYCLES < 1 || DATA_WIDTH < 1) begin : g_bad_params
            $error("systolic_array_tile_sequencer: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_W   = 3'd1,
        S_STREAM_A = 3'd2,
        S_DRAIN    = 3'd3,
        S_WAIT_OUT = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_act_beats;
    logic [CNT_WIDTH-1:0]   r_act_cnt;
    logic [CNT_WIDTH-1:0]   r_drn_cnt;
    logic [CNT_WIDTH-1:0]   r_out_cnt;
    logic [c_ROW_W-1:0]     r_row_cnt;
    logic                   r_proto_err;
    logic [CNT_WIDTH-1:0]   w_act_last_idx;
    logic                   w_last_act;
    logic                   w_m_beat;
    logic                   w_start_ok;

    assign w_act_last_idx = r_act_beats - c_ONE;
    assign w_last_act     = (r_act_cnt == w_act_last_idx);
    assign w_m_beat       = axis.m_tvalid & axis.m_tready;
    assign w_start_ok     = start & (act_beats != '0);

    assign busy           = (r_state != S_IDLE);
    assign proto_err      = r_proto_err;
    assign axis.out_last  = busy & (r_out_cnt == w_act_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        axis.s_tready = 1'b0;
        wgt_we        = 1'b0;
        wgt_row       = '0;
        act_en        = 1'b0;
        act_bubble    = 1'b0;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                axis.s_tready = 1'b1;
                wgt_row       = r_row_cnt;
                if (axis.s_tvalid) begin
                    wgt_we = 1'b1;
                    if (r_row_cnt == c_LAST_ROW) begin
                        w_state_nxt = S_STREAM_A;
                    end
                end
            end
            S_STREAM_A: begin
                axis.s_tready = ~out_afull;
                if (axis.s_tvalid && !out_afull) begin
                    act_en = 1'b1;
                    if (w_last_act) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_afull) begin
                    act_en     = 1'b1;
                    act_bubble = 1'b1;
                    if (r_drn_cnt == c_LAST_DRN) begin
                        w_state_nxt = S_WAIT_OUT;
                    end
                end
            end
            S_WAIT_OUT: begin
                if (r_out_cnt == r_act_beats) begin
                    done        = ~abort;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Abort overrides everything except an IDLE start
        if (abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_beats <= '0;
            r_act_cnt   <= '0;
            r_drn_cnt   <= '0;
            r_out_cnt   <= '0;
            r_row_cnt   <= '0;
            r_proto_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_act_cnt <= '0;
            r_drn_cnt <= '0;
            r_out_cnt <= '0;
            r_row_cnt <= '0;
            if (w_start_ok) begin
                r_act_beats <= act_beats;
                r_proto_err <= 1'b0;
            end
        end else if (w_state_nxt == S_IDLE) begin
            r_act_cnt <= '0;
            r_drn_cnt <= '0;
            r_out_cnt <= '0;
            r_row_cnt <= '0;
        end else begin
            if (wgt_we) begin
                r_row_cnt <= r_row_cnt + c_ROW_W'(1);
                if (axis.s_tlast) begin
                    r_proto_err <= 1'b1;
                end
            end
            if (act_en && !act_bubble) begin
                r_act_cnt <= r_act_cnt + c_ONE;
                // tlast must coincide exactly with the final counted activation
                if (axis.s_tlast != w_last_act) begin
                    r_proto_err <= 1'b1;
                end
            end
            if (act_bubble) begin
                r_drn_cnt <= r_drn_cnt + c_ONE;
            end
            if (w_m_beat && r_out_cnt != r_act_beats) begin
                r_out_cnt <= r_out_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_tile_sequencer
// Description : Scoreboard bench for the tile sequencer (ARRAY_DIM=4, DRAIN=7)
// Revision    : 1.0
// ============================================================================
module tb_systolic_array_tile_sequencer;

    localparam int AD = 4;
    localparam int DC = 7;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] act_beats;
    logic          out_afull;
    logic          wgt_we;
    logic [1:0]    wgt_row;
    logic          act_en;
    logic          act_bubble;
    logic          busy;
    logic          done;
    logic          proto_err;

    systolic_array_tile_sequencer_if ifc();

    systolic_array_tile_sequencer #(
        .DATA_WIDTH   (9),
        .ARRAY_DIM    (AD),
        .CNT_WIDTH    (CW),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .act_beats  (act_beats),
        .out_afull  (out_afull),
        .wgt_we     (wgt_we),
        .wgt_row    (wgt_row),
        .act_en     (act_en),
        .act_bubble (act_bubble),
        .busy       (busy),
        .done       (done),
        .proto_err  (proto_err),
        .axis       (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] q_wgt[$];
    int         q_act[$];
    int         q_bub[$];
    logic       q_mlast[$];
    logic       q_done[$];

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endfunction

    function automatic void chk_tok(string nm, int sz);
        n_checks++;
        if (sz == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected event, got 1 event, required 0", nm);
        end
    endfunction

    // Monitor: pops expected events whenever the DUT presents one
    always @(negedge clk) begin
        if (!rst) begin
            if (wgt_we) begin
                chk_tok("wgt_event", q_wgt.size());
                if (q_wgt.size() != 0) chk("wgt_row", 32'(wgt_row), 32'(q_wgt.pop_front()));
            end
            if (act_en && !act_bubble) begin
                chk_tok("act_event", q_act.size());
                if (q_act.size() != 0) void'(q_act.pop_front());
            end
            if (act_en && act_bubble) begin
                chk_tok("bubble_event", q_bub.size());
                if (q_bub.size() != 0) void'(q_bub.pop_front());
            end
            if (ifc.m_tvalid && ifc.m_tready && busy) begin
                chk_tok("m_beat_event", q_mlast.size());
                if (q_mlast.size() != 0) chk("out_last", 32'(ifc.out_last), 32'(q_mlast.pop_front()));
            end
            if (done) begin
                chk_tok("done_event", q_done.size());
                if (q_done.size() != 0) chk("proto_err_at_done", 32'(proto_err), 32'(q_done.pop_front()));
            end
        end
    end

    task automatic run_tile(input int nact, input int tlast_beat, input int afull_at,
                            input int afull_len, input bit exp_perr, input int abort_after);
        int k, sc, cyc, b;
        bit in_stream, perr_pending, got;
        for (int i = 0; i < AD; i++) q_wgt.push_back(2'(i));
        for (int i = 0; i < nact; i++) q_act.push_back(i);
        for (int i = 0; i < ((abort_after > 0) ? abort_after : DC); i++) q_bub.push_back(i);
        if (abort_after == 0) begin
            for (int i = 0; i < nact; i++) q_mlast.push_back(i == nact - 1);
            q_done.push_back(exp_perr);
        end
        @(posedge clk); #1;
        act_beats = CW'(nact);
        start     = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        ifc.s_tvalid = 1'b1;
        k = 0; sc = 0; cyc = 0; perr_pending = 1'b0;
        while (k < AD + nact && cyc < 300) begin
            in_stream   = (k >= AD);
            ifc.s_tlast = (k + 1 == tlast_beat);
            out_afull   = in_stream && afull_at >= 0 && sc >= afull_at && sc < afull_at + afull_len;
            @(negedge clk);
            if (cyc == 0) begin
                chk("busy_after_start", 32'(busy), 1);
                chk("proto_err_cleared", 32'(proto_err), 0);
            end
            if (perr_pending) begin
                chk("proto_err_early_tlast", 32'(proto_err), 1);
                chk("busy_after_early_tlast", 32'(busy), 1);
                perr_pending = 1'b0;
            end
            if (out_afull) begin
                chk("s_tready_afull", 32'(ifc.s_tready), 0);
                chk("act_en_afull", 32'(act_en), 0);
            end
            if (ifc.s_tready) begin
                k++;
                if (k == tlast_beat && k != AD + nact) perr_pending = 1'b1;
            end
            if (in_stream) sc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("input_beats", k, AD + nact);
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
        out_afull    = 1'b0;
        if (abort_after > 0) begin
            b = 0; cyc = 0;
            while (b < abort_after && cyc < 100) begin
                @(negedge clk);
                if (act_bubble) b++;
                if (b == abort_after) abort = 1'b1;
                else begin @(posedge clk); #1; end
                cyc++;
            end
            chk("bubbles_before_abort", b, abort_after);
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            chk("busy_after_abort", 32'(busy), 0);
            repeat (10) @(negedge clk);
        end else begin
            ifc.m_tvalid = 1'b1;
            ifc.m_tready = 1'b1;
            repeat (nact) begin @(posedge clk); #1; end
            ifc.m_tvalid = 1'b0;
            ifc.m_tready = 1'b0;
            got = 1'b0; cyc = 0;
            while (!got && cyc < 100) begin
                @(negedge clk);
                if (done) got = 1'b1;
                else begin @(posedge clk); #1; end
                cyc++;
            end
            chk("done_seen", 32'(got), 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 0);
            chk("done_one_cycle", 32'(done), 0);
        end
    endtask

    initial begin
        int k, cyc;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        act_beats    = '0;
        out_afull    = 1'b0;
        ifc.s_tvalid = 1'b0;
        ifc.s_tlast  = 1'b0;
        ifc.m_tvalid = 1'b0;
        ifc.m_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_tready", 32'(ifc.s_tready), 0);
        chk("rst_wgt_we", 32'(wgt_we), 0);
        chk("rst_wgt_row", 32'(wgt_row), 0);
        chk("rst_act_en", 32'(act_en), 0);
        chk("rst_act_bubble", 32'(act_bubble), 0);
        chk("rst_out_last", 32'(ifc.out_last), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // start with zero activation beats is ignored
        act_beats = '0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_beats_busy", 32'(busy), 0);
        chk("zero_beats_s_tready", 32'(ifc.s_tready), 0);
        repeat (3) @(posedge clk);

        run_tile(8, 12, -1, 0, 1'b0, 0);   // clean tile
        run_tile(8, 12,  2, 5, 1'b0, 0);   // afull stall mid-stream
        run_tile(8,  9, -1, 0, 1'b1, 0);   // early tlast
        run_tile(8, 12, -1, 0, 1'b0, 0);   // start clears proto_err
        run_tile(8, 12, -1, 0, 1'b0, 3);   // abort during drain
        run_tile(8, 12, -1, 0, 1'b0, 0);   // clean tile after abort
        run_tile(1,  5, -1, 0, 1'b0, 0);   // single activation beat

        // async reset while weight row 2 is presented
        for (int i = 0; i < 3; i++) q_wgt.push_back(2'(i));
        @(posedge clk); #1;
        act_beats = CW'(8);
        start     = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        ifc.s_tvalid = 1'b1;
        k = 0; cyc = 0;
        while (k < 3 && cyc < 20) begin
            @(negedge clk);
            if (ifc.s_tready) k++;
            if (k < 3) begin @(posedge clk); #1; end
            cyc++;
        end
        chk("rows_before_rst", k, 3);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_s_tready", 32'(ifc.s_tready), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_wgt_we", 32'(wgt_we), 0);
        chk("async_rst_act_en", 32'(act_en), 0);
        ifc.s_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        chk("q_wgt_left", q_wgt.size(), 0);
        chk("q_act_left", q_act.size(), 0);
        chk("q_bub_left", q_bub.size(), 0);
        chk("q_mlast_left", q_mlast.size(), 0);
        chk("q_done_left", q_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
